// File: rtl/game_phase_pkg.sv
// rtl/game_phase_pkg.sv - phase encodings, default IR codes and sizing helper for the game phase controller
package game_phase_pkg;

    typedef enum logic [2:0] {
        PH_START      = 3'd0,
        PH_COUNTDOWN  = 3'd1,
        PH_FIGHT      = 3'd2,
        PH_HIT_FREEZE = 3'd3,
        PH_LOSE       = 3'd4,
        PH_WIN        = 3'd5
    } phase_t;

    localparam logic [31:0] IR_START_A = 32'h20DF_5BA4;
    localparam logic [31:0] IR_START_B = 32'h20DF_5AA5;
    localparam logic [31:0] IR_RESTART = 32'h20DF_10EF;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/nf_frame_timer.sv
// rtl/nf_frame_timer.sv - new-frame pulse counter with clear, terminal value and saturate mode
module nf_frame_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         nf,
    input  logic         saturate,
    input  logic [W-1:0] terminal,
    output logic [W-1:0] count,
    output logic         tick
);

    assign tick = nf && (count == terminal);

    // At the terminal value the count either holds (saturate) or reloads to zero; it never wraps.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (nf) begin
            if (count == terminal) begin
                count <= saturate ? count : '0;
            end else begin
                count <= count + W'(1);
            end
        end
    end

endmodule

// File: rtl/game_phase_controller.sv
// rtl/game_phase_controller.sv - top-level Moore FSM sequencing menu, countdown, fight, freeze and end screens
module game_phase_controller
    import game_phase_pkg::*;
#(
    parameter logic [31:0] START_CODE_A      = IR_START_A,
    parameter logic [31:0] START_CODE_B      = IR_START_B,
    parameter logic [31:0] RESTART_CODE      = IR_RESTART,
    parameter int          COUNT_START       = 3,
    parameter int          COUNTDOWN_FRAMES  = 60,
    parameter int          HIT_FREEZE_FRAMES = 30,
    parameter int          END_HOLD_FRAMES   = 180
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] ir_in,
    input  logic        nf_in,
    input  logic [2:0]  player_health_in,
    input  logic [2:0]  opponent_health_in,
    output logic [2:0]  phase_out,
    output logic        display_start_out,
    output logic        end_lose_out,
    output logic        end_win_out,
    output logic [1:0]  countdown_digit_out,
    output logic        freeze_out,
    output logic        flash_player_out,
    output logic        flash_opponent_out,
    output logic        health_reset_out
);

    localparam int CW = $clog2(max3(COUNTDOWN_FRAMES, HIT_FREEZE_FRAMES, END_HOLD_FRAMES) + 1);
    localparam logic [CW-1:0] CD_TERM = CW'(COUNTDOWN_FRAMES - 1);
    localparam logic [CW-1:0] HF_TERM = CW'(HIT_FREEZE_FRAMES - 1);
    localparam logic [CW-1:0] EH_TERM = CW'(END_HOLD_FRAMES);

    phase_t      phase, nxt;
    logic [31:0] ir_prev;
    logic [2:0]  player_prev, opponent_prev;
    logic        start_ev, restart_ev, hit_p, hit_o;
    logic [1:0]  nxt_digit;
    logic        nxt_fp, nxt_fo, nxt_hr, abort, reload;
    logic        clear, saturate, tick;
    logic [CW-1:0] terminal, count;

    assign phase_out  = phase;
    assign start_ev   = (ir_in != ir_prev) && ((ir_in == START_CODE_A) || (ir_in == START_CODE_B));
    assign restart_ev = (ir_in != ir_prev) && (ir_in == RESTART_CODE);
    assign hit_p      = player_health_in < player_prev;
    assign hit_o      = opponent_health_in < opponent_prev;

    // Previous-value registers follow their inputs even in reset, so a held code never fires afterwards.
    always_ff @(posedge clk_in) begin
        ir_prev       <= ir_in;
        player_prev   <= player_health_in;
        opponent_prev <= opponent_health_in;
    end

    nf_frame_timer #(.W(CW)) u_timer (
        .clk      (clk_in),
        .rst      (rst_in),
        .clear    (clear),
        .nf       (nf_in),
        .saturate (saturate),
        .terminal (terminal),
        .count    (count),
        .tick     (tick)
    );

    always_comb begin
        nxt       = phase;
        nxt_digit = countdown_digit_out;
        nxt_fp    = flash_player_out;
        nxt_fo    = flash_opponent_out;
        nxt_hr    = 1'b0;
        abort     = 1'b0;
        reload    = 1'b0;
        case (phase)
            PH_START: begin
                nxt_digit = 2'd0;
                nxt_fp    = 1'b0;
                nxt_fo    = 1'b0;
                if (start_ev) begin
                    nxt       = PH_COUNTDOWN;
                    nxt_digit = 2'(COUNT_START);
                end
            end
            PH_COUNTDOWN: begin
                if (restart_ev) begin
                    abort = 1'b1;
                end else if (tick) begin
                    if (countdown_digit_out == 2'd1) begin
                        nxt       = PH_FIGHT;
                        nxt_digit = 2'd0;
                    end else begin
                        nxt_digit = countdown_digit_out - 2'd1;
                        reload    = 1'b1;
                    end
                end
            end
            PH_FIGHT: begin
                if (restart_ev) begin
                    abort = 1'b1;
                end else if (player_health_in == 3'd0) begin
                    nxt = PH_LOSE;
                end else if (opponent_health_in == 3'd0) begin
                    nxt = PH_WIN;
                end else if (hit_p || hit_o) begin
                    nxt    = PH_HIT_FREEZE;
                    nxt_fp = hit_p;
                    nxt_fo = hit_o;
                end
            end
            PH_HIT_FREEZE: begin
                if (restart_ev) begin
                    abort = 1'b1;
                end else if (player_health_in == 3'd0) begin
                    nxt    = PH_LOSE;
                    nxt_fp = 1'b0;
                    nxt_fo = 1'b0;
                end else if (opponent_health_in == 3'd0) begin
                    nxt    = PH_WIN;
                    nxt_fp = 1'b0;
                    nxt_fo = 1'b0;
                end else if (tick) begin
                    nxt    = PH_FIGHT;
                    nxt_fp = 1'b0;
                    nxt_fo = 1'b0;
                end
            end
            PH_LOSE, PH_WIN: begin
                if (restart_ev && (count == EH_TERM)) begin
                    nxt    = PH_START;
                    nxt_hr = 1'b1;
                end
            end
            default: begin
                nxt       = PH_START;
                nxt_digit = 2'd0;
                nxt_fp    = 1'b0;
                nxt_fo    = 1'b0;
            end
        endcase
        if (abort) begin
            nxt       = PH_START;
            nxt_hr    = 1'b1;
            nxt_digit = 2'd0;
            nxt_fp    = 1'b0;
            nxt_fo    = 1'b0;
        end

        // Every phase change starts the shared timer from zero; FIGHT and START never use it.
        clear    = (nxt != phase) || reload || (phase == PH_FIGHT) || (phase == PH_START);
        saturate = (phase == PH_LOSE) || (phase == PH_WIN);
        case (phase)
            PH_COUNTDOWN:  terminal = CD_TERM;
            PH_HIT_FREEZE: terminal = HF_TERM;
            default:       terminal = EH_TERM;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            phase               <= PH_START;
            countdown_digit_out <= 2'd0;
            flash_player_out    <= 1'b0;
            flash_opponent_out  <= 1'b0;
            health_reset_out    <= 1'b0;
            display_start_out   <= 1'b1;
            freeze_out          <= 1'b0;
            end_lose_out        <= 1'b0;
            end_win_out         <= 1'b0;
        end else begin
            phase               <= nxt;
            countdown_digit_out <= nxt_digit;
            flash_player_out    <= nxt_fp;
            flash_opponent_out  <= nxt_fo;
            health_reset_out    <= nxt_hr;
            display_start_out   <= (nxt == PH_START);
            freeze_out          <= (nxt != PH_FIGHT);
            end_lose_out        <= (nxt == PH_LOSE);
            end_win_out         <= (nxt == PH_WIN);
        end
    end

endmodule

// File: tb/tb_game_phase_controller.sv
// tb/tb_game_phase_controller.sv - directed self-checking bench for game_phase_controller
module tb_game_phase_controller;

    localparam logic [31:0] CODE_A   = 32'h20DF_5BA4;
    localparam logic [31:0] CODE_B   = 32'h20DF_5AA5;
    localparam logic [31:0] CODE_RST = 32'h20DF_10EF;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] ir_in;
    logic        nf_in;
    logic [2:0]  player_health_in;
    logic [2:0]  opponent_health_in;
    logic [2:0]  phase_out;
    logic        display_start_out;
    logic        end_lose_out;
    logic        end_win_out;
    logic [1:0]  countdown_digit_out;
    logic        freeze_out;
    logic        flash_player_out;
    logic        flash_opponent_out;
    logic        health_reset_out;

    int vectors = 0;
    int miscompares = 0;

    game_phase_controller dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .ir_in               (ir_in),
        .nf_in               (nf_in),
        .player_health_in    (player_health_in),
        .opponent_health_in  (opponent_health_in),
        .phase_out           (phase_out),
        .display_start_out   (display_start_out),
        .end_lose_out        (end_lose_out),
        .end_win_out         (end_win_out),
        .countdown_digit_out (countdown_digit_out),
        .freeze_out          (freeze_out),
        .flash_player_out    (flash_player_out),
        .flash_opponent_out  (flash_opponent_out),
        .health_reset_out    (health_reset_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            nf_in = 1'b1;
            step();
            nf_in = 1'b0;
            step();
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_in = 1'b1;
        ir_in = 32'h0;
        nf_in = 1'b0;
        player_health_in = 3'd3;
        opponent_health_in = 3'd3;
        step();
        step();
        chk("rst_phase", 32'(phase_out), 32'd0);
        chk("rst_display", 32'(display_start_out), 32'd1);
        chk("rst_freeze", 32'(freeze_out), 32'd0);
        chk("rst_digit", 32'(countdown_digit_out), 32'd0);
        chk("rst_hreset", 32'(health_reset_out), 32'd0);

        rst_in = 1'b0;
        step();
        chk("idle_freeze", 32'(freeze_out), 32'd1);
        ir_in = CODE_A;
        step();
        chk("start_phase", 32'(phase_out), 32'd1);
        chk("start_digit", 32'(countdown_digit_out), 32'd3);
        chk("start_display", 32'(display_start_out), 32'd0);
        repeat (100) step();
        chk("held_phase", 32'(phase_out), 32'd1);
        chk("held_digit", 32'(countdown_digit_out), 32'd3);
        frames(59);
        chk("cd59_digit", 32'(countdown_digit_out), 32'd3);
        frames(1);
        chk("cd60_digit", 32'(countdown_digit_out), 32'd2);
        frames(119);
        chk("cd179_digit", 32'(countdown_digit_out), 32'd1);
        chk("cd179_phase", 32'(phase_out), 32'd1);
        frames(1);
        chk("fight_phase", 32'(phase_out), 32'd2);
        chk("fight_freeze", 32'(freeze_out), 32'd0);
        chk("fight_digit", 32'(countdown_digit_out), 32'd0);

        opponent_health_in = 3'd2;
        step();
        chk("hit_phase", 32'(phase_out), 32'd3);
        chk("hit_flash_o", 32'(flash_opponent_out), 32'd1);
        chk("hit_flash_p", 32'(flash_player_out), 32'd0);
        chk("hit_freeze", 32'(freeze_out), 32'd1);
        player_health_in = 3'd2;
        step();
        chk("rehit_flash_p", 32'(flash_player_out), 32'd0);
        chk("rehit_phase", 32'(phase_out), 32'd3);
        frames(29);
        chk("hf29_phase", 32'(phase_out), 32'd3);
        frames(1);
        chk("hf30_phase", 32'(phase_out), 32'd2);
        chk("hf30_flash_o", 32'(flash_opponent_out), 32'd0);
        opponent_health_in = 3'd3;
        step();
        chk("heal_phase", 32'(phase_out), 32'd2);

        player_health_in = 3'd0;
        opponent_health_in = 3'd0;
        step();
        chk("both0_phase", 32'(phase_out), 32'd4);
        chk("both0_lose", 32'(end_lose_out), 32'd1);
        chk("both0_win", 32'(end_win_out), 32'd0);
        frames(180);
        ir_in = CODE_RST;
        step();
        chk("lose_rst_phase", 32'(phase_out), 32'd0);
        chk("lose_rst_hr", 32'(health_reset_out), 32'd1);
        step();
        chk("lose_rst_hr2", 32'(health_reset_out), 32'd0);

        player_health_in = 3'd3;
        opponent_health_in = 3'd3;
        step();
        ir_in = CODE_B;
        step();
        chk("startb_phase", 32'(phase_out), 32'd1);
        frames(60);
        chk("abort_pre_digit", 32'(countdown_digit_out), 32'd2);
        ir_in = CODE_RST;
        step();
        chk("abort_phase", 32'(phase_out), 32'd0);
        chk("abort_digit", 32'(countdown_digit_out), 32'd0);
        chk("abort_hr", 32'(health_reset_out), 32'd1);
        step();
        chk("abort_hr2", 32'(health_reset_out), 32'd0);

        ir_in = CODE_A;
        step();
        frames(180);
        chk("f2_phase", 32'(phase_out), 32'd2);
        opponent_health_in = 3'd0;
        step();
        chk("win_phase", 32'(phase_out), 32'd5);
        chk("win_flag", 32'(end_win_out), 32'd1);
        frames(100);
        ir_in = CODE_RST;
        step();
        chk("early_rst_phase", 32'(phase_out), 32'd5);
        chk("early_rst_hr", 32'(health_reset_out), 32'd0);
        ir_in = CODE_A;
        step();
        chk("win_start_ign", 32'(phase_out), 32'd5);
        frames(80);
        ir_in = CODE_RST;
        step();
        chk("win_rst_phase", 32'(phase_out), 32'd0);
        chk("win_rst_hr", 32'(health_reset_out), 32'd1);
        step();
        chk("win_rst_hr2", 32'(health_reset_out), 32'd0);

        opponent_health_in = 3'd3;
        ir_in = CODE_A;
        step();
        frames(180);
        opponent_health_in = 3'd2;
        step();
        chk("f3_hit_phase", 32'(phase_out), 32'd3);
        rst_in = 1'b1;
        step();
        chk("midrst_phase", 32'(phase_out), 32'd0);
        chk("midrst_flash", 32'(flash_opponent_out), 32'd0);
        chk("midrst_display", 32'(display_start_out), 32'd1);
        rst_in = 1'b0;
        repeat (5) step();
        chk("postrst_phase", 32'(phase_out), 32'd0);
        chk("postrst_digit", 32'(countdown_digit_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
